// File: rtl/sha256_padder.sv
// SHA-256 message padder: forwards 32-bit big-endian message words and appends
// the 0x80 marker, zero fill and 64-bit bit length as whole 16-word blocks.
module sha256_padder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_dat,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] blk_cnt_o
);

    typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO} state_t;

    state_t             state, state_nx;
    logic [3:0]         idx;
    logic [CNT_W-1:0]   byte_cnt;
    logic [2:0]         nb;
    logic [63:0]        bit_len;
    logic               accept;
    logic               wr;
    logic [31:0]        wr_dat;
    logic               len_next;

    assign bit_len  = 64'(byte_cnt) << 3;
    assign accept   = in_valid && in_ready;
    // The word being written now lands at idx; the length pair must start at 14.
    assign len_next = (idx == 4'd13);

    always_comb begin
        nb = 3'd4;
        if (in_last && (in_nbytes < 3'd4))
            nb = in_nbytes;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    if (!in_last)
                        state_nx = DATA;
                    else if (nb == 3'd4)
                        state_nx = PAD;
                    else
                        state_nx = len_next ? LEN_HI : ZERO;
                end
            end
            PAD:    if (!fifo_full) state_nx = len_next ? LEN_HI : ZERO;
            ZERO:   if (!fifo_full && len_next) state_nx = LEN_HI;
            LEN_HI: if (!fifo_full) state_nx = LEN_LO;
            LEN_LO: if (!fifo_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = rstn && !fifo_full && ((state == IDLE) || (state == DATA));
        wr       = 1'b0;
        wr_dat   = '0;
        case (state)
            IDLE, DATA: begin
                wr = accept;
                case (nb)
                    3'd0:    wr_dat = 32'h8000_0000;
                    3'd1:    wr_dat = {in_data[31:24], 8'h80, 16'h0000};
                    3'd2:    wr_dat = {in_data[31:16], 8'h80, 8'h00};
                    3'd3:    wr_dat = {in_data[31:8], 8'h80};
                    default: wr_dat = in_data;
                endcase
            end
            PAD: begin
                wr     = !fifo_full;
                wr_dat = 32'h8000_0000;
            end
            ZERO:   wr = !fifo_full;
            LEN_HI: begin
                wr     = !fifo_full;
                wr_dat = bit_len[63:32];
            end
            LEN_LO: begin
                wr     = !fifo_full;
                wr_dat = bit_len[31:0];
            end
            default: wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx         <= '0;
            byte_cnt    <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_wr_dat <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            blk_cnt_o   <= '0;
        end else begin
            fifo_wr_en  <= wr;
            fifo_wr_dat <= wr_dat;
            done_o      <= wr && (state == LEN_LO);

            if (wr)
                idx <= (state == LEN_LO) ? 4'd0 : idx + 4'd1;

            if (wr && (state == LEN_LO))
                byte_cnt <= '0;
            else if (accept)
                byte_cnt <= byte_cnt + CNT_W'(nb);

            // Block count survives the finished message until the next one starts.
            if (accept && (state == IDLE))
                blk_cnt_o <= '0;
            else if (wr && (idx == 4'd15))
                blk_cnt_o <= blk_cnt_o + 16'd1;

            if (accept && (state == IDLE))
                busy_o <= 1'b1;
            else if (wr && (state == LEN_LO))
                busy_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages, FIFO backpressure and
// mid-message reset, with expected FIFO words queued ahead of the DUT output.
module tb_sha256_padder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_nbytes = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_dat;
    logic        busy_o;
    logic        done_o;
    logic [15:0] blk_cnt_o;

    sha256_padder #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_dat(fifo_wr_dat),
        .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          msg_writes = 0;
    logic [31:0] last_dat = '0;
    bit          stall_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic exp_push(input logic [31:0] d, input bit last);
        exp_t x;
        x.dat  = d;
        x.last = last;
        sb.push_back(x);
    endtask

    // Byte-level reference padding of the pattern message.
    task automatic push_model(input int n);
        logic [7:0]  m[$];
        logic [63:0] bl;
        int          nw;
        bl = 64'(n) * 64'd8;
        for (int i = 0; i < n; i++) m.push_back(pat(i));
        m.push_back(8'h80);
        while ((m.size() % 64) != 56) m.push_back(8'h00);
        for (int b = 0; b < 8; b++) m.push_back(bl[63 - 8*b -: 8]);
        nw = m.size() / 4;
        for (int w = 0; w < nw; w++)
            exp_push({m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]}, w == nw - 1);
    endtask

    task automatic push_abc();
        exp_push(32'h6162_6380, 1'b0);
        for (int i = 0; i < 14; i++) exp_push(32'h0, 1'b0);
        exp_push(32'h0000_0018, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
        int unsigned n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Non-last words carry in_nbytes=1 to show it is ignored; spare bytes are 0xAA.
    task automatic send_pat(input int n);
        int nw;
        int rem;
        bit last;
        logic [31:0] d;
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            rem  = n - 4*w;
            last = (w == nw - 1);
            for (int b = 0; b < 4; b++) d[31 - 8*b -: 8] = (b < rem) ? pat(4*w + b) : 8'hAA;
            send_word(d, last, last ? 3'(rem) : 3'd1);
            if (w == 0) chk("busy_after_first", 64'(busy_o), 64'd1);
        end
    endtask

    task automatic wait_done(input string name, input int exp_blk, input logic [31:0] exp_last);
        int unsigned n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            seen = done_o;
            n++;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        chk({name, "_blk_cnt"}, 64'(blk_cnt_o), 64'(exp_blk));
        chk({name, "_writes"}, 64'(msg_writes), 64'(16 * exp_blk));
        chk({name, "_pending"}, 64'(sb.size()), 64'd0);
        chk({name, "_busy_end"}, 64'(busy_o), 64'd0);
        chk({name, "_len_lo"}, 64'(last_dat), 64'(exp_last));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            fifo_full = stall_en ? ($urandom_range(0, 99) < 45) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (fifo_full) chk("ready_when_full", 64'(in_ready), 64'd0);
            if (fifo_wr_en) begin
                msg_writes++;
                last_dat = fifo_wr_dat;
                if (sb.size() == 0) begin
                    chk("extra_write", 64'(fifo_wr_en), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_dat", 64'(fifo_wr_dat), 64'(e.dat));
                    chk("done_o", 64'(done_o), 64'(e.last));
                    if (e.last) chk("busy_at_done", 64'(busy_o), 64'd0);
                end
            end else if (done_o) begin
                chk("done_without_write", 64'(done_o), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_wr_dat", 64'(fifo_wr_dat), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_blk", 64'(blk_cnt_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        msg_writes = 0;
        push_abc();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        chk("abc_busy", 64'(busy_o), 64'd1);
        wait_done("abc", 1, 32'h0000_0018);

        msg_writes = 0;
        exp_push(32'h8000_0000, 1'b0);
        for (int i = 0; i < 13; i++) exp_push(32'h0, 1'b0);
        exp_push(32'h0, 1'b0);
        exp_push(32'h0, 1'b1);
        send_word(32'h1234_5678, 1'b1, 3'd0);
        wait_done("empty", 1, 32'h0);

        msg_writes = 0;
        push_model(55);
        send_pat(55);
        wait_done("b55", 1, 32'h0000_01B8);

        msg_writes = 0;
        push_model(56);
        send_pat(56);
        wait_done("b56", 2, 32'h0000_01C0);

        msg_writes = 0;
        stall_en = 1'b1;
        push_model(150);
        send_pat(150);
        wait_done("stall150", 3, 32'h0000_04B0);
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        msg_writes = 0;
        push_abc();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_blk", 64'(blk_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_wr_en_hold", 64'(fifo_wr_en), 64'd0);
        sb.delete();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        msg_writes = 0;
        push_abc();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        wait_done("abc_after_rst", 1, 32'h0000_0018);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
